// File: rtl/conv_pkg.sv
// Shared constants, state encoding and source-select codes for the
// convolution layer sequencer.
package conv_pkg;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int K      = 3;
    localparam int CH     = 64;
    localparam int ADDR_W = 10;
    localparam int LAT    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_HOST
    } state_t;

    localparam logic [1:0] SEL_IN      = 2'd0;
    localparam logic [1:0] SEL_KER     = 2'd1;
    localparam logic [1:0] SEL_OUT     = 2'd2;
    localparam logic [1:0] SEL_OUT_ALT = 2'd3;

    // Counter width for a range of `limit` values, never narrower than 1 bit.
    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// Five-level loop nest (m, n, mk, nk, ck) with ck innermost; advances only
// when en is high and flags the final tap of the layer.
module conv_loop_counter
    import conv_pkg::*;
#(
    parameter int IMG_W = conv_pkg::IMG_W,
    parameter int IMG_H = conv_pkg::IMG_H,
    parameter int K     = conv_pkg::K,
    parameter int CH    = conv_pkg::CH,
    parameter int MW    = cnt_w(IMG_H),
    parameter int NW    = cnt_w(IMG_W),
    parameter int KW    = cnt_w(K),
    parameter int CW    = cnt_w(CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [MW-1:0] m,
    output logic [NW-1:0] n,
    output logic [KW-1:0] mk,
    output logic [KW-1:0] nk,
    output logic [CW-1:0] ck,
    output logic          last
);

    logic m_max, n_max, mk_max, nk_max, ck_max;

    assign m_max  = (m  == MW'(IMG_H - 1));
    assign n_max  = (n  == NW'(IMG_W - 1));
    assign mk_max = (mk == KW'(K - 1));
    assign nk_max = (nk == KW'(K - 1));
    assign ck_max = (ck == CW'(CH - 1));
    assign last   = m_max & n_max & mk_max & nk_max & ck_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            m  <= '0;
            n  <= '0;
            mk <= '0;
            nk <= '0;
            ck <= '0;
        end else if (en) begin
            if (!ck_max) begin
                ck <= ck + 1'b1;
            end else begin
                ck <= '0;
                if (!nk_max) begin
                    nk <= nk + 1'b1;
                end else begin
                    nk <= '0;
                    if (!mk_max) begin
                        mk <= mk + 1'b1;
                    end else begin
                        mk <= '0;
                        if (!n_max) begin
                            n <= n + 1'b1;
                        end else begin
                            n <= '0;
                            m <= m_max ? '0 : m + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Sequences the 3x3 convolution datapath over the feature map, issues BRAM
// addresses and accumulate controls, and lends the address ports to the host.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W  = conv_pkg::IMG_W,
    parameter int IMG_H  = conv_pkg::IMG_H,
    parameter int K      = conv_pkg::K,
    parameter int CH     = conv_pkg::CH,
    parameter int ADDR_W = conv_pkg::ADDR_W,
    parameter int LAT    = conv_pkg::LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              host_req,
    input  logic [11:0]       host_addr,
    output logic              busy,
    output logic              done,
    output logic              host_grant,
    output logic [1:0]        sel,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] k_addr,
    output logic [ADDR_W-1:0] out_rd_addr,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic              out_we,
    output logic              acc_valid,
    output logic              acc_first,
    output logic              pad_skip,
    output logic [5:0]        ch_idx
);

    localparam int MW = cnt_w(IMG_H);
    localparam int NW = cnt_w(IMG_W);
    localparam int KW = cnt_w(K);
    localparam int CW = cnt_w(CH);
    localparam int DW = cnt_w(LAT);

    function automatic logic signed [6:0] offset(input int pos, input int tap);
        return 7'(pos + 1 - tap);
    endfunction

    function automatic logic outside(input logic signed [6:0] o, input int lim);
        return (int'(o) < 0) || (int'(o) >= lim);
    endfunction

    function automatic logic [ADDR_W-1:0] lin_addr(input int row, input int col);
        return ADDR_W'(row * IMG_W + col);
    endfunction

    state_t            state, state_next;
    logic [DW-1:0]     drain_cnt;
    logic              vld_p0;
    logic              last_tap;
    logic [MW-1:0]     m;
    logic [NW-1:0]     n;
    logic [KW-1:0]     mk, nk;
    logic [CW-1:0]     ck;

    logic signed [6:0] om_p0, on_p0;
    logic              pad_p0, first_p0;
    logic [ADDR_W-1:0] in_addr_p0, k_addr_p0, out_addr_p0, host_word;

    logic [LAT-1:0]              wb_we_p;
    logic [LAT-1:0][ADDR_W-1:0]  wb_addr_p;

    conv_loop_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .CH    (CH)
    ) u_loop (
        .clk  (clk),
        .rst  (rst_n),
        .en   (vld_p0),
        .m    (m),
        .n    (n),
        .mk   (mk),
        .nk   (nk),
        .ck   (ck),
        .last (last_tap)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state;
        vld_p0     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)         state_next = ST_RUN;
                else if (host_req) state_next = ST_HOST;
            end
            ST_RUN: begin
                if (!stall) begin
                    vld_p0 = 1'b1;
                    if (last_tap) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DW'(LAT - 1)) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_HOST: begin
                if (!host_req) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Stage p0: tap geometry from the live loop counters
    always_comb begin
        om_p0       = offset(int'(m), int'(mk));
        on_p0       = offset(int'(n), int'(nk));
        pad_p0      = outside(om_p0, IMG_H) | outside(on_p0, IMG_W);
        first_p0    = ((mk == '0) | (m == '0)) & ((nk == '0) | (n == '0)) & !pad_p0;
        in_addr_p0  = lin_addr(int'(m), int'(n));
        k_addr_p0   = ADDR_W'((K * int'(mk) + int'(nk)) * CH + int'(ck));
        out_addr_p0 = pad_p0 ? '0 : lin_addr(int'(om_p0), int'(on_p0));
        host_word   = ADDR_W'(host_addr[11:2]);
    end

    // Stage p1: registered tap / host outputs; held while nothing is issued
    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            host_grant  <= 1'b0;
            sel         <= 2'b00;
            in_addr     <= '0;
            k_addr      <= '0;
            out_rd_addr <= '0;
            acc_valid   <= 1'b0;
            acc_first   <= 1'b0;
            pad_skip    <= 1'b0;
            ch_idx      <= '0;
        end else begin
            busy       <= (state == ST_RUN) || (state == ST_DRAIN);
            done       <= (state == ST_DONE);
            host_grant <= (state == ST_HOST);
            acc_valid  <= vld_p0;
            if (vld_p0) begin
                in_addr     <= in_addr_p0;
                k_addr      <= k_addr_p0;
                out_rd_addr <= out_addr_p0;
                acc_first   <= first_p0;
                pad_skip    <= pad_p0;
                ch_idx      <= 6'(ck);
            end else if (state == ST_HOST) begin
                in_addr     <= host_word;
                k_addr      <= host_word;
                out_rd_addr <= host_word;
                sel         <= host_addr[1:0];
            end
        end
    end

    // Stages p2..p(LAT+1): write-back delay line, free-running even under stall
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wb_we_p   <= '0;
            wb_addr_p <= '0;
        end else begin
            wb_we_p[0]   <= acc_valid & ~pad_skip;
            wb_addr_p[0] <= out_rd_addr;
            for (int i = 1; i < LAT; i++) begin
                wb_we_p[i]   <= wb_we_p[i-1];
                wb_addr_p[i] <= wb_addr_p[i-1];
            end
        end
    end

    assign out_we      = wb_we_p[LAT-1];
    assign out_wr_addr = wb_addr_p[LAT-1];

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench: full-size sequencer for tap, host, stall and reset checks;
// a reduced 4x4x2-channel instance for whole-layer counts and done timing.
module tb_conv_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stall, host_req;
    logic [11:0] host_addr;
    logic        busy, done, host_grant, out_we, acc_valid, acc_first, pad_skip;
    logic [1:0]  sel;
    logic [9:0]  in_addr, k_addr, out_rd_addr, out_wr_addr;
    logic [5:0]  ch_idx;

    logic        s_rst, s_start, s_stall, s_host_req;
    logic [11:0] s_host_addr;
    logic        s_busy, s_done, s_host_grant, s_out_we, s_acc_valid, s_acc_first, s_pad_skip;
    logic [1:0]  s_sel;
    logic [9:0]  s_in_addr, s_k_addr, s_out_rd_addr, s_out_wr_addr;
    logic [5:0]  s_ch_idx;

    int   checks = 0;
    int   errors = 0;
    int   wc, nd, dc;
    logic bd;

    conv_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .busy        (busy),
        .done        (done),
        .host_grant  (host_grant),
        .sel         (sel),
        .in_addr     (in_addr),
        .k_addr      (k_addr),
        .out_rd_addr (out_rd_addr),
        .out_wr_addr (out_wr_addr),
        .out_we      (out_we),
        .acc_valid   (acc_valid),
        .acc_first   (acc_first),
        .pad_skip    (pad_skip),
        .ch_idx      (ch_idx)
    );

    conv_sequencer #(.IMG_W(4), .IMG_H(4), .CH(2)) dut_s (
        .clk         (clk),
        .rst_n       (s_rst),
        .start       (s_start),
        .stall       (s_stall),
        .host_req    (s_host_req),
        .host_addr   (s_host_addr),
        .busy        (s_busy),
        .done        (s_done),
        .host_grant  (s_host_grant),
        .sel         (s_sel),
        .in_addr     (s_in_addr),
        .k_addr      (s_k_addr),
        .out_rd_addr (s_out_rd_addr),
        .out_wr_addr (s_out_wr_addr),
        .out_we      (s_out_we),
        .acc_valid   (s_acc_valid),
        .acc_first   (s_acc_first),
        .pad_skip    (s_pad_skip),
        .ch_idx      (s_ch_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_tap0(input string tag);
        check({tag, "_in_addr"},   32'(in_addr),     0);
        check({tag, "_k_addr"},    32'(k_addr),      0);
        check({tag, "_out_rd"},    32'(out_rd_addr), 33);
        check({tag, "_acc_first"}, 32'(acc_first),   1);
        check({tag, "_pad_skip"},  32'(pad_skip),    0);
        check({tag, "_acc_valid"}, 32'(acc_valid),   1);
        check({tag, "_busy"},      32'(busy),        1);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; stall = 1'b0; host_req = 1'b0; host_addr = 12'h000;
        s_rst = 1'b1; s_start = 1'b0; s_stall = 1'b0; s_host_req = 1'b0; s_host_addr = 12'h000;
        tick();
        tick();
        rst_n = 1'b0;
        s_rst = 1'b0;

        check("rst_busy",       32'(busy),       0);
        check("rst_done",       32'(done),       0);
        check("rst_out_we",     32'(out_we),     0);
        check("rst_in_addr",    32'(in_addr),    0);
        check("rst_host_grant", 32'(host_grant), 0);
        check("rst_acc_valid",  32'(acc_valid),  0);

        // Host read-out: word 41, source 1
        host_addr = 12'h0A5;
        host_req  = 1'b1;
        tick();
        tick();
        check("host_grant", 32'(host_grant),  1);
        check("host_in",    32'(in_addr),     41);
        check("host_k",     32'(k_addr),      41);
        check("host_out",   32'(out_rd_addr), 41);
        check("host_sel",   32'(sel),         1);
        check("host_busy",  32'(busy),        0);
        host_req = 1'b0;
        tick();
        tick();
        check("host_release", 32'(host_grant), 0);

        // start and host_req together: RUN wins
        start    = 1'b1;
        host_req = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_tap0("tap0");
        check("tap0_no_grant", 32'(host_grant), 0);
        host_req = 1'b0;

        repeat (4) tick();
        check("we_before_lat", 32'(out_we), 0);
        tick();
        check("we_tap0",      32'(out_we),      1);
        check("wr_addr_tap0", 32'(out_wr_addr), 33);
        check("tap5_k_addr",  32'(k_addr),      5);
        check("tap5_ch_idx",  32'(ch_idx),      5);

        repeat (379) tick();
        check("tap384_k_addr",    32'(k_addr),      384);
        check("tap384_pad",       32'(pad_skip),    1);
        check("tap384_first",     32'(acc_first),   0);
        check("tap384_out_rd",    32'(out_rd_addr), 0);
        check("tap384_acc_valid", 32'(acc_valid),   1);
        repeat (5) tick();
        check("tap384_no_we", 32'(out_we), 0);
        check("tap389_k",     32'(k_addr), 389);

        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_acc_valid", 32'(acc_valid), 0);
            check("stall_k_frozen",  32'(k_addr),    389);
        end
        stall = 1'b0;
        tick();
        check("unstall_k",      32'(k_addr),    390);
        check("unstall_ch",     32'(ch_idx),    6);
        check("unstall_valid",  32'(acc_valid), 1);

        repeat (220) tick();
        check("tap610_in",    32'(in_addr),     1);
        check("tap610_k",     32'(k_addr),      34);
        check("tap610_out",   32'(out_rd_addr), 34);
        check("tap610_first", 32'(acc_first),   1);
        check("tap605_we",    32'(out_we),      1);
        check("tap605_wr",    32'(out_wr_addr), 34);

        // Reset mid-run with write-backs still in flight
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("mrst_in",     32'(in_addr),     0);
        check("mrst_k",      32'(k_addr),      0);
        check("mrst_out_rd", 32'(out_rd_addr), 0);
        check("mrst_out_wr", 32'(out_wr_addr), 0);
        check("mrst_we",     32'(out_we),      0);
        check("mrst_valid",  32'(acc_valid),   0);
        check("mrst_first",  32'(acc_first),   0);
        check("mrst_pad",    32'(pad_skip),    0);
        check("mrst_ch",     32'(ch_idx),      0);
        check("mrst_busy",   32'(busy),        0);
        check("mrst_done",   32'(done),        0);
        check("mrst_grant",  32'(host_grant),  0);
        check("mrst_sel",    32'(sel),         0);
        wc = 0;
        repeat (8) begin
            tick();
            if (out_we) wc++;
        end
        check("mrst_we_count", 32'(wc),   0);
        check("mrst_idle",     32'(busy), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_tap0("restart");
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;

        // Reduced instance: whole layer without stall
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wc = 0; nd = 0; dc = 0; bd = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (s_out_we) wc++;
            if (s_done) begin
                nd++;
                if (dc == 0) begin
                    dc = k;
                    bd = s_busy;
                end
            end
        end
        check("s_we_count",     32'(wc),     200);
        check("s_done_cycle",   32'(dc),     294);
        check("s_done_pulses",  32'(nd),     1);
        check("s_busy_at_done", 32'(bd),     0);
        check("s_busy_after",   32'(s_busy), 0);

        // Reduced instance: same layer with a 10-cycle stall
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wc = 0; nd = 0; dc = 0; bd = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            s_stall = (k >= 50) && (k < 60);
            tick();
            if (s_out_we) wc++;
            if (s_done) begin
                nd++;
                if (dc == 0) begin
                    dc = k;
                    bd = s_busy;
                end
            end
        end
        s_stall = 1'b0;
        check("s_stall_we_count",    32'(wc),     200);
        check("s_stall_done_cycle",  32'(dc),     304);
        check("s_stall_done_pulses", 32'(nd),     1);
        check("s_stall_busy_after",  32'(s_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
